// File: rtl/fft8_frame_loader_if.sv
// Stream-in / frame-out bundle between the sample source, the frame loader and the FFT core.
interface fft8_frame_loader_if #(
    parameter int DATA_W = 32,
    parameter int N      = 8,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0]   s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [N*DATA_W-1:0] frame_data;
    logic                frame_valid;
    logic                frame_short;
    logic                frame_ready;
    logic [CNT_W-1:0]    frame_cnt;

    modport slave (
        input  s_data, s_valid, s_last, frame_ready,
        output s_ready, frame_data, frame_valid, frame_short, frame_cnt
    );

    modport master (
        output s_data, s_valid, s_last, frame_ready,
        input  s_ready, frame_data, frame_valid, frame_short, frame_cnt
    );
endinterface

// File: rtl/fft8_frame_loader.sv
// Packs a serial sample stream into N-lane frames held in a ping-pong pair of banks
// until the FFT core accepts them; short frames (closed by s_last) are zero-padded.
module fft8_frame_loader #(
    parameter int DATA_W = 32,
    parameter int N      = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    fft8_frame_loader_if.slave  bus
);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int FRM_W  = N * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic             r_wr_bank, r_wr_bank_next;
    logic             r_rd_bank, r_rd_bank_next;
    logic [IDX_W-1:0] r_idx, r_idx_next;
    logic [1:0]       r_full, r_full_next;
    logic [1:0]       r_short, r_short_next;
    logic [CNT_W-1:0] r_cnt, r_cnt_next;

    logic             w_s_ready;
    logic             w_accept;
    logic             w_close;
    logic             w_handoff;
    logic [2*FRM_W-1:0] w_banks;

    assign w_s_ready = !r_full[r_wr_bank] && !rst;
    assign w_accept  = bus.s_valid && w_s_ready;
    assign w_close   = w_accept && ((r_idx == LAST_IDX) || bus.s_last);
    assign w_handoff = r_full[r_rd_bank] && bus.frame_ready;

    // A closing write needs an empty bank and a handoff needs a full one,
    // so when both happen in one cycle they always touch different banks.
    always_comb begin
        r_wr_bank_next = r_wr_bank;
        r_rd_bank_next = r_rd_bank;
        r_idx_next     = r_idx;
        r_full_next    = r_full;
        r_short_next   = r_short;
        r_cnt_next     = r_cnt;

        if (w_accept) begin
            if (w_close) begin
                r_full_next[r_wr_bank]  = 1'b1;
                r_short_next[r_wr_bank] = (r_idx != LAST_IDX);
                r_wr_bank_next          = ~r_wr_bank;
                r_idx_next              = '0;
            end else begin
                r_idx_next = r_idx + IDX_W'(1);
            end
        end

        if (w_handoff) begin
            r_full_next[r_rd_bank] = 1'b0;
            r_rd_bank_next         = ~r_rd_bank;
            r_cnt_next             = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_idx     <= '0;
            r_full    <= '0;
            r_short   <= '0;
            r_cnt     <= '0;
        end else begin
            r_wr_bank <= r_wr_bank_next;
            r_rd_bank <= r_rd_bank_next;
            r_idx     <= r_idx_next;
            r_full    <= r_full_next;
            r_short   <= r_short_next;
            r_cnt     <= r_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [FRM_W-1:0] r_data;
            logic             w_sel;

            assign w_sel = w_accept && (r_wr_bank == 1'(gi));

            // Lanes above the current index are cleared on close so that a
            // short frame never exposes stale samples from an older frame.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (w_sel) begin
                    for (int k = 0; k < N; k++) begin
                        if (k == int'(r_idx)) begin
                            r_data[k*DATA_W +: DATA_W] <= bus.s_data;
                        end else if (w_close && (k > int'(r_idx))) begin
                            r_data[k*DATA_W +: DATA_W] <= '0;
                        end
                    end
                end
            end

            assign w_banks[gi*FRM_W +: FRM_W] = r_data;
        end
    endgenerate

    assign bus.s_ready     = w_s_ready;
    assign bus.frame_valid = r_full[r_rd_bank];
    assign bus.frame_short = r_short[r_rd_bank];
    assign bus.frame_data  = r_rd_bank ? w_banks[FRM_W +: FRM_W] : w_banks[0 +: FRM_W];
    assign bus.frame_cnt   = r_cnt;
endmodule

// File: doc/fft8_frame_loader.md
# fft8_frame_loader

Input framing stage for the 8-point Q4.28 FFT core. It accepts a serial valid/ready stream of signed Q4.28 samples and packs each group of 8 into a parallel frame. Frames are ping-pong double-buffered and held stable on a flat bus until the FFT side accepts them. The lanes of `frame_data` drive the FFT core's `x0_real`…`x7_real` inputs directly.

## Interface
- `DATA_W`, default 32: sample width, signed Q4.28 when 32.
- `N`, default 8: samples per frame. Fixed at 8 for the FFT core; the index counter is `$clog2(N)` bits.
- `CNT_W`, default 16: width of the emitted-frame counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in DATA_W: input sample, signed Q4.28.
- `s_valid` in 1: `s_data` is valid.
- `s_last` in 1: marks the final sample of a short frame. Sampled only on accepted beats.
- `s_ready` out 1: loader can accept a sample this cycle.
- `frame_data` out N*DATA_W: lane k occupies bits [k*DATA_W +: DATA_W]. Lane 0 is the first sample received.
- `frame_valid` out 1: `frame_data` holds a complete frame.
- `frame_short` out 1: the current frame was closed early by `s_last` and zero-padded.
- `frame_ready` in 1: the FFT side accepts the frame.
- `frame_cnt` out CNT_W: count of frames handed off. Wraps modulo 2^CNT_W.

## Operation
- Storage is two banks `bank[0..1]`, each N×DATA_W wide, plus one short flag per bank.
- Control registers:
  - `wr_bank` (1 bit)
  - `rd_bank` (1 bit)
  - `idx` (0..N-1)
  - `full[1:0]`
- Each bank is either EMPTY (`full=0`) or FULL (`full=1`). A bank is filling when it is EMPTY and equals `wr_bank`.
- `s_ready = !full[wr_bank] && !rst`.
- Accept condition: `s_valid && s_ready`. On accept, write `s_data` into `bank[wr_bank]` lane `idx`.
- Frame close happens on an accepted beat with `idx==N-1` or `s_last==1`:
  - Lanes `idx+1..N-1` of `bank[wr_bank]` are written to 0 in the same cycle.
  - `short[wr_bank]` is set to (`idx!=N-1`).
  - `full[wr_bank]` is set to 1, `wr_bank` toggles, and `idx` returns to 0.
- Otherwise an accepted beat increments `idx`.
- `s_last` on lane N-1 closes a normal frame (`short=0`). A missing `s_last` is never an error; frames close at N samples regardless.
- Output side:
  - `frame_valid = full[rd_bank]`.
  - `frame_data = bank[rd_bank]`.
  - `frame_short = short[rd_bank]`.
- Handoff (`frame_valid && frame_ready`): clear `full[rd_bank]`, toggle `rd_bank`, increment `frame_cnt`.
- Sample data is stored bit-exact: no rounding, no saturation, sign preserved.

## Timing
- Reset state, effective on the first edge with `rst=1`:
  - `wr_bank=rd_bank=0`, `idx=0`, `full=0`, `short=0`, `frame_cnt=0`.
  - Both banks cleared to 0.
  - `s_ready=0` while `rst` is high and 1 on the first cycle after release.
  - `frame_valid=0`, `frame_short=0`, `frame_data=0`.
- A reset mid-frame discards the partial frame and any held frames. No frame is emitted for them.
- Latency: a frame that closes on the edge at cycle t shows `frame_valid=1` in cycle t+1.
- `frame_data` and `frame_short` are stable while `frame_valid=1 && frame_ready=0`.
- Throughput: with `frame_ready` tied high, one sample per cycle is sustained indefinitely. There are no bubbles at frame boundaries.
- Backpressure: with `frame_ready=0`, 2N samples are accepted. `s_ready` drops in the cycle after the 2N-th accept. `s_ready` returns the cycle after the first handoff.
- Simultaneous close and handoff in one cycle act on different banks, and both take effect.
- When both banks are empty, `wr_bank==rd_bank` and no handoff is possible.
- `frame_valid` stays asserted with no sample input; it never times out.

## Test plan
- Sample values are written as hexadecimal, 1.0 = 0x10000000. The `N` samples 0x10000000 ×4 followed by 0x00000000 ×4, with `frame_ready=1` → `frame_valid` pulses one cycle after the 8th accept. Lanes 0-3 = 0x10000000, lanes 4-7 = 0. `frame_short=0`, `frame_cnt=1`.
- Samples 0xF0000000 (−1.0), 0x08000000 (0.5), then 0x7FFFFFFF ×6 → lanes hold exactly those bit patterns and the sign is preserved.
- Samples 1, 2, 3 with `s_last` on the 3rd → lanes 0-2 = 1, 2, 3 and lanes 3-7 = 0. `frame_short=1`. The next 8 samples form a normal frame with `frame_short=0`.
- `frame_ready=0` and 20 samples offered back-to-back → 16 are accepted and `s_ready` is 0 from the 17th offer. `frame_data` is held stable. Then `frame_ready=1` for one cycle → frame 0 (samples 0-7) is handed off, `s_ready` is 1 the next cycle, and samples 16-19 go to lanes 0-3.
- 4 frames (32 samples) streamed continuously with `frame_ready=1` → no cycle with `s_ready=0`, `frame_cnt=4`, and frames appear in order.
- `rst` pulsed after 5 samples of a frame, with one full frame held → `frame_valid=0` the next cycle. The following 8 samples form a frame containing only post-reset data, and `frame_cnt` restarts at 1.
